wshb_arbiter: RTL
=================

WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter DW, default 32, Wishbone data width (byte selects DW/8).
REQ-003 SHALL have parameter MAX_HOLD, default 64, acks granted to one master before pre-emption; 0 disables pre-emption.
REQ-004 SHALL have the port clk  in  1  single system clock; all state on its rising edge.
REQ-005 SHALL have the port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have the ports m0_cyc, m0_stb, m0_we  in  1 each  master 0 (framebuffer reader) classic Wishbone controls.
REQ-007 SHALL have the ports m0_adr  in  AW, m0_dat_w  in  DW, m0_sel  in  DW/8  master 0 address, write data, byte selects.
REQ-008 SHALL have the ports m0_dat_r  out  DW, m0_ack  out  1  master 0 read data and acknowledge.
REQ-009 SHALL have m1_* ports identical to m0_* for master 1 (pattern writer).
REQ-010 SHALL have the ports s_cyc, s_stb, s_we  out  1, s_adr  out  AW, s_dat_w  out  DW, s_sel  out  DW/8  toward the shared SDRAM slave.
REQ-011 SHALL have the ports s_dat_r  in  DW, s_ack  in  1  slave read data and acknowledge.
REQ-012 SHALL have the port gnt  out  2  one-hot registered grant (bit0 = m0, bit1 = m1), 00 when idle.

Function
REQ-013 SHALL implement FSM states IDLE, G0, G1; gnt = 00/01/10 respectively.
REQ-014 SHALL hold register last (last-granted master); after reset last = 1 so m0 wins the first tie.
REQ-015 IDLE: one mx_cyc high -> Gx next edge; both high -> master != last; none -> stay IDLE.
REQ-016 Grant latency SHALL be exactly 1 clock from mx_cyc sampled high in IDLE to gnt asserted.
REQ-017 In Gx: s_cyc = mx_cyc, s_stb = mx_stb & ~mask, s_we/s_adr/s_dat_w/s_sel = mx_*, combinational from gnt.
REQ-018 In IDLE: all s_* outputs SHALL be 0.
REQ-019 mx_ack SHALL equal s_ack only while gnt selects x; the non-granted master's ack SHALL be 0.
REQ-020 m0_dat_r and m1_dat_r SHALL both be driven by s_dat_r (broadcast; qualified by ack).
REQ-021 Hold counter SHALL increment on each s_ack in Gx, saturate at MAX_HOLD, clear to 0 on every grant change and in IDLE; width clog2(MAX_HOLD+1).
REQ-022 Release: in Gx, mx_cyc low at an edge -> G(other) if other cyc high (no IDLE gap), else IDLE; last <= x.
REQ-023 Pre-emption (MAX_HOLD>0): in Gx, other cyc high and either (s_ack=1 and counter+1 >= MAX_HOLD) or (counter >= MAX_HOLD and mx_stb=0) -> G(other) next edge; last <= x.
REQ-024 Pre-emption SHALL never occur with mx_stb high and s_ack low (no transfer cut mid-cycle).
REQ-025 A pre-empted master keeping cyc high SHALL see ack = 0 and SHALL be re-granted per REQ-022/023 as an ordinary requester.
REQ-026 mask SHALL be 0 in Gx except the cycle of a pending grant switch decided at that edge (no stb leak to slave during handover).
REQ-027 Simultaneous release of x and assertion of other cyc SHALL hand over in one edge.
REQ-028 Both cyc dropping in same cycle in Gx SHALL go to IDLE.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, gnt = 00, last = 1, counter = 0, hence s_cyc = s_stb = 0 and m0_ack = m1_ack = 0.
REQ-030 Reset asserted mid-transfer SHALL abort it; after rst_n rises, arbitration restarts per REQ-015 at the first edge.

Verification
REQ-031 Reset, then m0_cyc/stb high alone -> gnt = 01 after 1 clock, s_adr = m0_adr, m0_ack mirrors s_ack, m1_ack = 0.
REQ-032 m0 and m1 cyc raised same cycle from reset -> gnt = 01 first; m0 drops cyc -> gnt = 10 next edge with no IDLE cycle.
REQ-033 MAX_HOLD = 4, m0 continuous burst, m1 cyc high -> after 4th m0 ack gnt = 10; m0_ack stays 0 until m1 releases; then gnt = 01.
REQ-034 MAX_HOLD = 0, m0 1000-ack burst with m1 waiting -> gnt stays 01 throughout; m1 granted only after m0_cyc low.
REQ-035 Slave delays ack 5 clocks on m0 read with hold limit reached and m1 waiting -> no grant switch before s_ack; s_stb never asserted for m1 while m0 transfer pending.
REQ-036 rst_n pulsed low 1 ns mid-transfer in G1 -> s_cyc = 0 and gnt = 00 immediately; after release with both cyc high -> gnt = 01.

Source files
------------

// File: rtl/wshb_arbiter.sv
// Two-master classic Wishbone arbiter for a shared SDRAM slave.
// Round-robin ties, hold-limit pre-emption, no IDLE gap on handover.
module wshb_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  input  logic [DW/8-1:0] m0_sel,
  output logic [DW-1:0]   m0_dat_r,
  output logic            m0_ack,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  input  logic [DW/8-1:0] m1_sel,
  output logic [DW-1:0]   m1_dat_r,
  output logic            m1_ack,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  output logic [DW/8-1:0] s_sel,
  input  logic [DW-1:0]   s_dat_r,
  input  logic            s_ack,
  output logic [1:0]      gnt
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam bit PRE = (MAX_HOLD > 0);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } state_t;

  state_t        state;
  logic          last;
  logic [CW-1:0] cnt;

  logic own_cyc, own_stb, oth_cyc;
  logic busy, hit_ack, hit_idle;
  logic sw, go_idle, mask;

  assign gnt = state;

  // Current owner's and other master's request lines
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    oth_cyc = 1'b0;
    unique case (1'b1)
      gnt[0]: begin
        own_cyc = m0_cyc;
        own_stb = m0_stb;
        oth_cyc = m1_cyc;
      end
      gnt[1]: begin
        own_cyc = m1_cyc;
        own_stb = m1_stb;
        oth_cyc = m0_cyc;
      end
      default: ;
    endcase
  end

  assign busy     = (state != IDLE);
  assign hit_ack  = PRE && s_ack
                    && ((int'(cnt) + 1) >= MAX_HOLD);
  assign hit_idle = PRE && !own_stb
                    && (int'(cnt) >= MAX_HOLD);
  assign sw       = busy && oth_cyc
                    && (!own_cyc || hit_ack || hit_idle);
  assign go_idle  = busy && !own_cyc && !oth_cyc;
  // Mask never depends on s_ack: an acked strobe must stay up
  assign mask     = busy && oth_cyc
                    && (!own_cyc || hit_idle);

  // Grant FSM, last-granted tracking and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (m0_cyc && m1_cyc)
            state <= last ? G0 : G1;
          else if (m0_cyc)
            state <= G0;
          else if (m1_cyc)
            state <= G1;
        end
        G0, G1: begin
          if (sw) begin
            state <= (state == G0) ? G1 : G0;
            last  <= (state == G1);
            cnt   <= '0;
          end else if (go_idle) begin
            state <= IDLE;
            last  <= (state == G1);
            cnt   <= '0;
          end else if (s_ack && (int'(cnt) < MAX_HOLD)) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Slave-side mux, all zero while idle
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    unique case (1'b1)
      gnt[0]: begin
        s_cyc   = m0_cyc;
        s_stb   = m0_stb & ~mask;
        s_we    = m0_we;
        s_adr   = m0_adr;
        s_dat_w = m0_dat_w;
        s_sel   = m0_sel;
      end
      gnt[1]: begin
        s_cyc   = m1_cyc;
        s_stb   = m1_stb & ~mask;
        s_we    = m1_we;
        s_adr   = m1_adr;
        s_dat_w = m1_dat_w;
        s_sel   = m1_sel;
      end
      default: ;
    endcase
  end

  assign m0_ack   = gnt[0] & s_ack;
  assign m1_ack   = gnt[1] & s_ack;
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

endmodule
